output_forward: RTL and testbench

Forward-pass output neuron. It accumulates a stream of (hidden activation, output weight) pairs into one unsigned dot product. The result is driven as the 23-bit network output, which the output-layer backprop stage consumes as its final value. The block sits between the hidden-layer neurons / weight store and the backprop stage, and is sequenced by the top state machine through start_i and the final_valid_o/final_ready_i handshake.

---
 rtl/output_forward_if.sv | 29 ++
 rtl/output_forward.sv | 105 ++++++++++
 tb/tb_output_forward.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/output_forward_if.sv
// Handshake/data bundle between the output neuron and its producers/consumer.
// Slave modport is the neuron side; master modport is the sequencer/testbench side.
// Pair stream is valid/ready; the result is held under final_valid_o/final_ready_i.
interface output_forward_if #(
   parameter int HID_W = 10,
   parameter int W_W   = 8,
   parameter int ACC_W = 23
);
   logic             start_i;
   logic             pair_valid_i;
   logic             pair_ready_o;
   logic [HID_W-1:0] hidden_val_i;
   logic [W_W-1:0]   w_i;
   logic [ACC_W-1:0] final_o;
   logic             final_valid_o;
   logic             final_ready_i;
   logic             busy_o;
   logic             f_end_o;

   modport slave (
      input  start_i, pair_valid_i, hidden_val_i, w_i, final_ready_i,
      output pair_ready_o, final_o, final_valid_o, busy_o, f_end_o
   );

   modport master (
      output start_i, pair_valid_i, hidden_val_i, w_i, final_ready_i,
      input  pair_ready_o, final_o, final_valid_o, busy_o, f_end_o
   );
endinterface

// File: rtl/output_forward.sv
// Output neuron: accumulates N_HIDDEN (hidden, weight) products into one dot product.
// Latency: final_valid_o rises the edge after the last pair; N_HIDDEN+1 cycles minimum.
// Backpressure: pairs stall on pair_valid_i=0; result held in DONE until final_ready_i.
// Optional macro SAT_EN: saturate the accumulator at 2^ACC_W-1 instead of wrapping.
module output_forward #(
   parameter int N_HIDDEN = 2,
   parameter int HID_W    = 10,
   parameter int W_W      = 8,
   parameter int ACC_W    = 23
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output_forward_if.slave   io_bus
);

   localparam int CNT_W  = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
   localparam int PROD_W = HID_W + W_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_HIDDEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [PROD_W-1:0] w_prod;
   logic [ACC_W-1:0] w_acc_add;

   assign w_prod = io_bus.hidden_val_i * io_bus.w_i;

`ifdef SAT_EN
   // One extra bit catches the carry out; once at max, any further add carries again
   logic [ACC_W:0] w_sum;
   assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(w_prod);
   assign w_acc_add = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   assign w_acc_add = r_acc + ACC_W'(w_prod);
`endif

   // The result is the accumulator itself: cleared on start, held after the handshake
   assign io_bus.final_o = r_acc;

   // State, accumulator and pair counter registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, datapath update and handshake outputs
   always_comb begin
      w_state_nxt          = r_state;
      w_acc_nxt            = r_acc;
      w_cnt_nxt            = r_cnt;
      io_bus.pair_ready_o  = 1'b0;
      io_bus.final_valid_o = 1'b0;
      io_bus.busy_o        = 1'b0;
      io_bus.f_end_o       = 1'b0;
      case (r_state)
         IDLE: begin
            if (io_bus.start_i) begin
               w_acc_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            io_bus.pair_ready_o = 1'b1;
            io_bus.busy_o       = 1'b1;
            if (io_bus.pair_valid_i) begin
               w_acc_nxt = w_acc_add;
               w_cnt_nxt = r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            io_bus.final_valid_o = 1'b1;
            io_bus.busy_o        = 1'b1;
            // start_i is deliberately not looked at here: a new pass needs a fresh start in IDLE
            if (io_bus.final_ready_i) begin
               io_bus.f_end_o = 1'b1;
               w_state_nxt    = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_output_forward.sv
// Directed bench for output_forward: table of two-pair passes on an N_HIDDEN=2 instance,
// plus hand sequences for mid-pass reset, N_HIDDEN=64 wrap/saturate and N_HIDDEN=1.
// Inputs change #1 after the rising edge; outputs are checked in that same window.
module tb_output_forward;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   output_forward_if if2  ();
   output_forward_if if64 ();
   output_forward_if if1  ();

   output_forward #(.N_HIDDEN(2))  u_dut2  (.clk_i(clk), .rst_i(rst_n), .io_bus(if2.slave));
   output_forward #(.N_HIDDEN(64)) u_dut64 (.clk_i(clk), .rst_i(rst_n), .io_bus(if64.slave));
   output_forward #(.N_HIDDEN(1))  u_dut1  (.clk_i(clk), .rst_i(rst_n), .io_bus(if1.slave));

   typedef struct {
      int h0;
      int w0;
      int h1;
      int w1;
      int gap;        // idle cycles (pair_valid_i=0) between the two pairs
      int rdy_dly;    // cycles final_ready_i is held low in DONE
      bit start_rel;  // drive start_i together with final_ready_i
      int exp;
   } vec_t;

   vec_t vt [5];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full pass on the N_HIDDEN=2 instance, starting from IDLE
   task automatic run_pass(input vec_t v, input int prev);
      chk("idle_keeps_prev", if2.final_o, prev);
      chk("idle_busy", if2.busy_o, 0);
      chk("idle_pair_rdy", if2.pair_ready_o, 0);
      if2.start_i = 1'b1;
      tick();
      if2.start_i = 1'b0;
      chk("start_clears", if2.final_o, 0);
      chk("accum_pair_rdy", if2.pair_ready_o, 1);
      chk("accum_busy", if2.busy_o, 1);
      if2.pair_valid_i = 1'b1;
      if2.hidden_val_i = 10'(v.h0);
      if2.w_i          = 8'(v.w0);
      tick();
      // junk on the data lanes while not valid must not be summed
      if2.pair_valid_i = 1'b0;
      if2.hidden_val_i = 10'd1023;
      if2.w_i          = 8'd255;
      chk("no_early_valid", if2.final_valid_o, 0);
      for (int g = 0; g < v.gap; g++) begin
         tick();
         chk("gap_pair_rdy", if2.pair_ready_o, 1);
         chk("gap_no_valid", if2.final_valid_o, 0);
      end
      if2.pair_valid_i = 1'b1;
      if2.hidden_val_i = 10'(v.h1);
      if2.w_i          = 8'(v.w1);
      tick();
      if2.pair_valid_i = 1'b0;
      chk("done_valid", if2.final_valid_o, 1);
      chk("done_result", if2.final_o, v.exp);
      chk("done_pair_rdy", if2.pair_ready_o, 0);
      for (int d = 0; d < v.rdy_dly; d++) begin
         // start and pairs offered during DONE must both be ignored
         if2.start_i      = 1'b1;
         if2.pair_valid_i = 1'b1;
         #1;
         chk("hold_no_fend", if2.f_end_o, 0);
         tick();
         chk("hold_valid", if2.final_valid_o, 1);
         chk("hold_result", if2.final_o, v.exp);
      end
      if2.pair_valid_i  = 1'b0;
      if2.start_i       = v.start_rel;
      if2.final_ready_i = 1'b1;
      #1;
      chk("fend_pulse", if2.f_end_o, 1);
      tick();
      if2.final_ready_i = 1'b0;
      if2.start_i       = 1'b0;
      chk("post_valid", if2.final_valid_o, 0);
      chk("post_fend", if2.f_end_o, 0);
      chk("post_busy", if2.busy_o, 0);
      chk("post_result_kept", if2.final_o, v.exp);
      tick();
      chk("no_restart", if2.busy_o, 0);
   endtask

   initial begin
      vec_t v;
      if2.start_i = 0;  if2.pair_valid_i = 0;  if2.hidden_val_i = 0;  if2.w_i = 0;  if2.final_ready_i = 0;
      if64.start_i = 0; if64.pair_valid_i = 0; if64.hidden_val_i = 0; if64.w_i = 0; if64.final_ready_i = 0;
      if1.start_i = 0;  if1.pair_valid_i = 0;  if1.hidden_val_i = 0;  if1.w_i = 0;  if1.final_ready_i = 0;

      vt[0] = '{3, 5, 10, 2, 0, 0, 1'b0, 35};
      vt[1] = '{1023, 255, 1023, 255, 2, 0, 1'b0, 521730};
      vt[2] = '{3, 5, 10, 2, 0, 4, 1'b0, 35};
      vt[3] = '{100, 100, 200, 50, 1, 1, 1'b1, 20000};
      vt[4] = '{0, 0, 5, 5, 0, 0, 1'b0, 25};

      // Reset state
      tick();
      tick();
      chk("rst_final", if2.final_o, 0);
      chk("rst_valid", if2.final_valid_o, 0);
      chk("rst_pair_rdy", if2.pair_ready_o, 0);
      chk("rst_busy", if2.busy_o, 0);
      chk("rst_fend", if2.f_end_o, 0);
      chk("rst_busy64", if64.busy_o, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_pass(vt[i], (i == 0) ? 0 : vt[i-1].exp);
      end

      // Reset in the middle of a pass discards the partial sum
      if2.start_i = 1'b1;
      tick();
      if2.start_i      = 1'b0;
      if2.pair_valid_i = 1'b1;
      if2.hidden_val_i = 10'd7;
      if2.w_i          = 8'd9;
      tick();
      if2.pair_valid_i = 1'b0;
      chk("mid_partial", if2.final_o, 63);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_busy", if2.busy_o, 0);
      chk("mid_rst_final", if2.final_o, 0);
      chk("mid_rst_pair_rdy", if2.pair_ready_o, 0);
      chk("mid_rst_valid", if2.final_valid_o, 0);
      v = '{2, 2, 4, 4, 0, 0, 1'b0, 20};
      run_pass(v, 0);

      // N_HIDDEN=64, every pair at full scale
      if64.start_i = 1'b1;
      tick();
      if64.start_i      = 1'b0;
      if64.pair_valid_i = 1'b1;
      if64.hidden_val_i = 10'd1023;
      if64.w_i          = 8'd255;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (i == 62) chk("n64_not_early", if64.final_valid_o, 0);
      end
      if64.pair_valid_i = 1'b0;
      chk("n64_valid", if64.final_valid_o, 1);
`ifdef SAT_EN
      chk("n64_result", if64.final_o, 8388607);
`else
      chk("n64_result", if64.final_o, 8306752);
`endif
      if64.final_ready_i = 1'b1;
      #1;
      chk("n64_fend", if64.f_end_o, 1);
      tick();
      if64.final_ready_i = 1'b0;
      chk("n64_idle", if64.busy_o, 0);

      // N_HIDDEN=1: a single accepted pair completes the pass
      if1.start_i = 1'b1;
      tick();
      if1.start_i      = 1'b0;
      if1.pair_valid_i = 1'b1;
      if1.hidden_val_i = 10'd0;
      if1.w_i          = 8'd200;
      tick();
      if1.pair_valid_i = 1'b0;
      chk("n1_valid_a", if1.final_valid_o, 1);
      chk("n1_result_a", if1.final_o, 0);
      if1.final_ready_i = 1'b1;
      tick();
      if1.final_ready_i = 1'b0;
      chk("n1_idle", if1.busy_o, 0);
      if1.start_i = 1'b1;
      tick();
      if1.start_i      = 1'b0;
      if1.pair_valid_i = 1'b1;
      if1.hidden_val_i = 10'd1;
      if1.w_i          = 8'd1;
      tick();
      if1.pair_valid_i = 1'b0;
      chk("n1_valid_b", if1.final_valid_o, 1);
      chk("n1_result_b", if1.final_o, 1);
      if1.final_ready_i = 1'b1;
      #1;
      chk("n1_fend", if1.f_end_o, 1);
      tick();
      if1.final_ready_i = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
